fetch_stage: RTL

//  Fetch stage of the pipelined ARM-subset core, directly upstream of decode.

---
 rtl/fetch_stage.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Fetch stage of the pipelined ARM-subset core.
// Owns PCF, keeps at most one instruction-memory request in flight, and absorbs
// variable memory latency. Applies execute/writeback redirects and drives the
// IF/ID register that feeds decode.
module fetch_stage #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StallF,
    input  logic             StallD,
    input  logic             FlushD,
    input  logic             BranchTakenE,
    input  logic [WIDTH-1:0] ALUResultE,
    input  logic             PCSrcW,
    input  logic [WIDTH-1:0] ResultW,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_rvalid,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0] InstructionD,
    output logic [WIDTH-1:0] PCPlus8D,
    output logic             ValidD
);

    localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);
    localparam logic [WIDTH-1:0] PC_R15  = WIDTH'(8);

    // ISSUE:   ready to send a request for PCF
    // WAIT:    request outstanding, response will be used
    // HOLD:    response captured while decode was stalled
    // DISCARD: request outstanding, but a redirect made its response stale
    typedef enum logic [1:0] {
        S_ISSUE,
        S_WAIT,
        S_HOLD,
        S_DISCARD
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] pcf;
    logic [WIDTH-1:0] hold_instr;
    logic [WIDTH-1:0] hold_pc8;

    logic             redir;
    logic [WIDTH-1:0] target;
    logic             load;
    logic [WIDTH-1:0] load_instr;
    logic [WIDTH-1:0] load_pc8;

    // Redirect select and the IF/ID load source for this cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned; that is what keeps latches from being inferred.
        redir      = BranchTakenE | PCSrcW;
        target     = BranchTakenE ? ALUResultE : ResultW;
        load       = 1'b0;
        load_instr = imem_rdata;
        load_pc8   = pcf + PC_R15;
        case (state)
            S_WAIT: begin
                if (!redir && imem_rvalid && !StallD) begin
                    load = 1'b1;
                end
            end
            S_HOLD: begin
                if (!redir && !StallD) begin
                    load       = 1'b1;
                    load_instr = hold_instr;
                    load_pc8   = hold_pc8;
                end
            end
            default: begin
                load = 1'b0;
            end
        endcase
    end

    // The request is accepted in the cycle it is raised; a redirect in the
    // same cycle wins, so the old PCF is never sent.
    assign imem_req  = ~reset & (state == S_ISSUE) & ~StallF & ~redir;
    assign imem_addr = pcf;

    // Fetch FSM, PCF and IF/ID register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (reset) begin
            state        <= S_ISSUE;
            pcf          <= RESET_PC;
            InstructionD <= '0;
            PCPlus8D     <= '0;
            ValidD       <= 1'b0;
            // NOTE: hold_instr/hold_pc8 are data-only and always written in
            // WAIT before HOLD reads them, so they need no reset.
        end else begin
            case (state)
                S_ISSUE: begin
                    // A response arriving here belongs to an abandoned request.
                    if (redir) begin
                        pcf <= target;
                    end else if (imem_req) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (redir) begin
                        pcf   <= target;
                        state <= imem_rvalid ? S_ISSUE : S_DISCARD;
                    end else if (imem_rvalid) begin
                        pcf <= pcf + PC_STEP;
                        if (StallD) begin
                            hold_instr <= imem_rdata;
                            hold_pc8   <= pcf + PC_R15;
                            state      <= S_HOLD;
                        end else begin
                            state <= S_ISSUE;
                        end
                    end
                end
                S_HOLD: begin
                    if (redir) begin
                        pcf   <= target;
                        state <= S_ISSUE;
                    end else if (!StallD) begin
                        state <= S_ISSUE;
                    end
                end
                S_DISCARD: begin
                    if (redir) begin
                        pcf <= target;
                    end
                    if (imem_rvalid) begin
                        state <= S_ISSUE;
                    end
                end
                default: begin
                    state <= S_ISSUE;
                end
            endcase

            // Flush beats stall beats load; otherwise decode sees a bubble.
            if (FlushD) begin
                InstructionD <= '0;
                ValidD       <= 1'b0;
            end else if (StallD) begin
                InstructionD <= InstructionD;
            end else if (load) begin
                InstructionD <= load_instr;
                PCPlus8D     <= load_pc8;
                ValidD       <= 1'b1;
            end else begin
                InstructionD <= '0;
                ValidD       <= 1'b0;
            end
        end
    end

endmodule
